// File: rtl/watch_pkg.sv
// Shared definitions for the watch timekeeper.
//   mode_e      : operating mode encoding presented on the mode output
//   *_MAX       : last legal value of each time field before it wraps to 00
//   next_mode() : mode sequence advanced once per mode button event
package watch_pkg;

  typedef enum logic [1:0] {
    ModeRun     = 2'd0,
    ModeSetHour = 2'd1,
    ModeSetMin  = 2'd2
  } mode_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  // Tens-digit widths needed to hold each field's maximum.
  localparam int unsigned SEC_TENS_W = 3;
  localparam int unsigned MIN_TENS_W = 3;
  localparam int unsigned HR_TENS_W  = 2;

  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      ModeRun:     nxt = ModeSetHour;
      ModeSetHour: nxt = ModeSetMin;
      ModeSetMin:  nxt = ModeRun;
      default:     nxt = ModeRun;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..MAX_VAL and wraps to 00.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears to 00)
//   i_clr          : synchronous clear to 00, has priority over i_inc
//   i_inc          : advance by one
//   o_tens, o_ones : registered BCD digits
//   o_carry        : combinational, high when an increment wraps MAX_VAL -> 00
module bcd_mod_counter #(
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned TENS_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [TENS_W-1:0] o_tens,
  output logic [3:0]        o_ones,
  output logic              o_carry
);

  localparam logic [TENS_W-1:0] MaxTens = TENS_W'(MAX_VAL / 10);
  localparam logic [3:0]        MaxOnes = 4'(MAX_VAL % 10);

  logic [TENS_W-1:0] r_tens, w_tens_d;
  logic [3:0]        r_ones, w_ones_d;
  logic              w_at_max;

  assign w_at_max = (r_tens == MaxTens) && (r_ones == MaxOnes);

  always_comb begin
    w_tens_d = r_tens;
    w_ones_d = r_ones;
    if (i_clr) begin
      w_tens_d = '0;
      w_ones_d = '0;
    end else if (i_inc) begin
      if (w_at_max) begin
        w_tens_d = '0;
        w_ones_d = '0;
      end else if (r_ones == 4'd9) begin
        w_tens_d = r_tens + TENS_W'(1);
        w_ones_d = '0;
      end else begin
        w_ones_d = r_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tens <= '0;
      r_ones <= '0;
    end else begin
      r_tens <= w_tens_d;
      r_ones <= w_ones_d;
    end
  end

  assign o_tens  = r_tens;
  assign o_ones  = r_ones;
  assign o_carry = i_inc & ~i_clr & w_at_max;

endmodule

// File: rtl/watch_timekeeper.sv
// 24-hour HH:MM:SS watch core with a two-button set interface.
//   clk_27Mhz, reset_n : clock, asynchronous active-low reset
//   tick_1hz           : 1 Hz square wave, already synchronous to clk_27Mhz
//   btn_mode, btn_inc  : asynchronous debounced buttons (synchronized here)
//   hr_*/min_*/sec_*   : registered BCD time digits
//   mode               : 0 = run, 1 = set hours, 2 = set minutes
//   day_wrap           : one-cycle pulse with the 23:59:59 -> 00:00:00 update
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_27Mhz,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       day_wrap
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end

  // ---------------------------------------------------------------------------
  // Button synchronizers and rising-edge detectors
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_mode_sync, r_inc_sync;
  logic                   r_mode_q, r_inc_q;
  logic                   w_mode_ev, w_inc_ev;

  always_ff @(posedge clk_27Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_sync <= '0;
      r_inc_sync  <= '0;
      r_mode_q    <= 1'b0;
      r_inc_q     <= 1'b0;
    end else begin
      r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], btn_mode};
      r_inc_sync  <= {r_inc_sync[SYNC_STAGES-2:0], btn_inc};
      r_mode_q    <= r_mode_sync[SYNC_STAGES-1];
      r_inc_q     <= r_inc_sync[SYNC_STAGES-1];
    end
  end

  assign w_mode_ev = r_mode_sync[SYNC_STAGES-1] & ~r_mode_q;
  assign w_inc_ev  = r_inc_sync[SYNC_STAGES-1] & ~r_inc_q;

  // ---------------------------------------------------------------------------
  // Seconds strobe. r_tick_armed stays low for the first cycle after reset so
  // a tick that is already high at release is taken as the previous level
  // rather than as a fresh rising edge.
  // ---------------------------------------------------------------------------
  logic r_tick_q, r_tick_armed;
  logic w_sec_strobe;

  always_ff @(posedge clk_27Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_q     <= 1'b0;
      r_tick_armed <= 1'b0;
    end else begin
      r_tick_q     <= tick_1hz;
      r_tick_armed <= 1'b1;
    end
  end

  assign w_sec_strobe = tick_1hz & ~r_tick_q & r_tick_armed;

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_e r_mode, w_mode_d;

  always_comb begin
    w_mode_d = r_mode;
    unique case (r_mode)
      ModeRun, ModeSetHour, ModeSetMin: begin
        if (w_mode_ev) w_mode_d = next_mode(r_mode);
      end
      default: w_mode_d = ModeRun;
    endcase
  end

  always_ff @(posedge clk_27Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= ModeRun;
    end else begin
      r_mode <= w_mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter control. A mode event always wins: it blocks the seconds strobe
  // (and so the whole carry chain) and discards a coincident inc event.
  // Carries only propagate in run mode so setting a field never disturbs
  // its neighbours.
  // ---------------------------------------------------------------------------
  logic w_run, w_set_hr, w_set_min;
  logic w_sec_clr, w_sec_inc, w_min_inc, w_hr_inc;
  logic w_sec_carry, w_min_carry, w_hr_carry;

  assign w_run     = (r_mode == ModeRun);
  assign w_set_hr  = (r_mode == ModeSetHour);
  assign w_set_min = (r_mode == ModeSetMin);

  // Seconds are held at 00 for the whole time the watch is being set.
  assign w_sec_clr = ~w_run | w_mode_ev;
  assign w_sec_inc = w_run & ~w_mode_ev & w_sec_strobe;
  assign w_min_inc = (w_run & w_sec_carry) | (w_set_min & ~w_mode_ev & w_inc_ev);
  assign w_hr_inc  = (w_run & w_min_carry) | (w_set_hr & ~w_mode_ev & w_inc_ev);

  bcd_mod_counter #(
    .MAX_VAL (SEC_MAX),
    .TENS_W  (SEC_TENS_W)
  ) u_sec (
    .i_clk   (clk_27Mhz),
    .i_rst_n (reset_n),
    .i_clr   (w_sec_clr),
    .i_inc   (w_sec_inc),
    .o_tens  (sec_tens),
    .o_ones  (sec_ones),
    .o_carry (w_sec_carry)
  );

  bcd_mod_counter #(
    .MAX_VAL (MIN_MAX),
    .TENS_W  (MIN_TENS_W)
  ) u_min (
    .i_clk   (clk_27Mhz),
    .i_rst_n (reset_n),
    .i_clr   (1'b0),
    .i_inc   (w_min_inc),
    .o_tens  (min_tens),
    .o_ones  (min_ones),
    .o_carry (w_min_carry)
  );

  bcd_mod_counter #(
    .MAX_VAL (HR_MAX),
    .TENS_W  (HR_TENS_W)
  ) u_hr (
    .i_clk   (clk_27Mhz),
    .i_rst_n (reset_n),
    .i_clr   (1'b0),
    .i_inc   (w_hr_inc),
    .o_tens  (hr_tens),
    .o_ones  (hr_ones),
    .o_carry (w_hr_carry)
  );

  // Registered alongside the digits so the pulse lines up with 00:00:00.
  logic r_day_wrap;

  always_ff @(posedge clk_27Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_day_wrap <= 1'b0;
    end else begin
      r_day_wrap <= w_run & w_hr_carry;
    end
  end

  assign day_wrap = r_day_wrap;
  assign mode     = r_mode;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Scoreboard bench for watch_timekeeper: directed stimulus pushes expected
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_watch_timekeeper;

  localparam int S = 2;

  logic       clk_27Mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       tick_1hz  = 1'b0;
  logic       btn_mode  = 1'b0;
  logic       btn_inc   = 1'b0;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode;
  logic       day_wrap;

  watch_timekeeper #(
    .SYNC_STAGES (S)
  ) dut (
    .clk_27Mhz (clk_27Mhz),
    .reset_n   (reset_n),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hr_tens   (hr_tens),
    .hr_ones   (hr_ones),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .mode      (mode),
    .day_wrap  (day_wrap)
  );

  always #5 clk_27Mhz = ~clk_27Mhz;

  typedef struct {
    string name;
    int    hr;
    int    mn;
    int    sc;
    int    md;
    int    wrap;
    int    wcnt;
  } exp_t;

  exp_t sb_q[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wrap_seen = 0;

  function automatic void cmp(input string n, input string f, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
    end
  endfunction

  // Monitor: counts day_wrap pulses and checks each requested snapshot.
  always @(negedge clk_27Mhz) begin
    exp_t e;
    if (day_wrap) wrap_seen++;
    if (chk_req) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got request expected queued entry");
      end else begin
        e = sb_q.pop_front();
        cmp(e.name, "hr", int'(hr_tens) * 10 + int'(hr_ones), e.hr);
        cmp(e.name, "min", int'(min_tens) * 10 + int'(min_ones), e.mn);
        cmp(e.name, "sec", int'(sec_tens) * 10 + int'(sec_ones), e.sc);
        cmp(e.name, "mode", int'(mode), e.md);
        cmp(e.name, "day_wrap", int'(day_wrap), e.wrap);
        cmp(e.name, "wrap_count", wrap_seen, e.wcnt);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_27Mhz);
    #1;
  endtask

  // Push an expected snapshot and have the monitor check it at the next negedge.
  task automatic check_now(input string n, input int h, input int m, input int s,
                           input int md, input int w, input int wc);
    exp_t e;
    e.name = n; e.hr = h; e.mn = m; e.sc = s; e.md = md; e.wrap = w; e.wcnt = wc;
    sb_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk_27Mhz);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cycles(2);
      tick_1hz = 1'b0;
      cycles(2);
    end
  endtask

  task automatic press(input bit do_mode, input bit do_inc, input int n);
    for (int i = 0; i < n; i++) begin
      btn_mode = do_mode;
      btn_inc  = do_inc;
      cycles(S + 3);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cycles(S + 3);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state while held in reset, then count a full minute.
    cycles(3);
    check_now("in_reset", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cycles(2);
    check_now("after_reset", 0, 0, 0, 0, 0, 0);
    ticks(60);
    check_now("one_minute", 0, 1, 0, 0, 0, 0);

    // Fresh start, then set hours through a full wrap and minutes likewise.
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    press(1, 0, 1);
    check_now("enter_set_hour", 0, 0, 0, 1, 0, 0);
    press(0, 1, 25);
    check_now("hour_25_incs", 1, 0, 0, 1, 0, 0);
    press(1, 0, 1);
    press(0, 1, 61);
    check_now("min_61_incs", 1, 1, 0, 2, 0, 0);
    ticks(5);
    check_now("set_min_frozen", 1, 1, 0, 2, 0, 0);
    press(1, 0, 1);
    check_now("back_to_run", 1, 1, 0, 0, 0, 0);
    ticks(1);
    check_now("resume_count", 1, 1, 1, 0, 0, 0);

    // Both buttons together in run: mode wins, inc discarded, seconds cleared.
    press(1, 1, 1);
    check_now("mode_and_inc", 1, 1, 0, 1, 0, 0);
    ticks(5);
    check_now("set_hour_frozen", 1, 1, 0, 1, 0, 0);

    // Preload 23:59 and roll the day over.
    press(0, 1, 22);
    press(1, 0, 1);
    press(0, 1, 58);
    press(1, 0, 1);
    check_now("preload_2359", 23, 59, 0, 0, 0, 0);
    ticks(59);
    check_now("at_235959", 23, 59, 59, 0, 0, 0);
    tick_1hz = 1'b1;
    @(posedge clk_27Mhz);
    #1;
    check_now("day_wrap_pulse", 0, 0, 0, 0, 1, 1);
    @(posedge clk_27Mhz);
    #1;
    check_now("day_wrap_gone", 0, 0, 0, 0, 0, 1);
    tick_1hz = 1'b0;
    cycles(2);

    // Mode event coincident with a strobe at :59 -> clear wins, no carry.
    ticks(59);
    check_now("at_0059", 0, 0, 59, 0, 0, 1);
    cycles(1);
    btn_mode = 1'b1;
    repeat (S) @(posedge clk_27Mhz);
    #1;
    tick_1hz = 1'b1;
    @(posedge clk_27Mhz);
    #1;
    check_now("mode_vs_strobe", 0, 0, 0, 1, 0, 1);
    tick_1hz = 1'b0;
    cycles(S + 3);
    btn_mode = 1'b0;
    cycles(S + 3);

    // Set 12:34, run to 12:34:56, then reset mid-cycle.
    press(0, 1, 12);
    press(1, 0, 1);
    press(0, 1, 34);
    press(1, 0, 1);
    ticks(56);
    check_now("at_123456", 12, 34, 56, 0, 0, 1);
    cycles(1);
    #1;
    reset_n = 1'b0;
    #1;
    check_now("async_reset", 0, 0, 0, 0, 0, 1);

    // Tick already high across reset release must not strobe.
    tick_1hz = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(6);
    check_now("tick_high_at_release", 0, 0, 0, 0, 0, 1);
    tick_1hz = 1'b0;
    cycles(2);
    tick_1hz = 1'b1;
    cycles(2);
    check_now("next_tick_counts", 0, 0, 1, 0, 0, 1);
    tick_1hz = 1'b0;
    cycles(2);

    // Button held across reset release gives exactly one event.
    reset_n  = 1'b0;
    btn_mode = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(20);
    check_now("held_mode_one_event", 0, 0, 0, 1, 0, 1);
    btn_mode = 1'b0;
    cycles(S + 3);

    // Held inc in set-minutes: one increment, exactly S+1 cycles after assertion.
    press(1, 0, 1);
    check_now("enter_set_min", 0, 0, 0, 2, 0, 1);
    cycles(1);
    btn_inc = 1'b1;
    for (int k = 1; k <= S + 1; k++) begin
      @(posedge clk_27Mhz);
      #1;
      if (k == S) check_now("inc_before_latency", 0, 0, 0, 2, 0, 1);
      if (k == S + 1) check_now("inc_at_latency", 0, 1, 0, 2, 0, 1);
    end
    cycles(1000 - (S + 1));
    check_now("inc_held_1000", 0, 1, 0, 2, 0, 1);
    btn_inc = 1'b0;
    cycles(S + 3);
    check_now("inc_released", 0, 1, 0, 2, 0, 1);

    cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/watch_timekeeper.md
WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, flip-flop stages on each asynchronous button input (legal 2..4).
REQ-002 SHALL have port clk_27Mhz  input  1  27 MHz user clock; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick_1hz  input  1  divided 1 Hz square wave, generated synchronous to clk_27Mhz.
REQ-005 SHALL have port btn_mode  input  1  debounced mode button, asynchronous, active-high.
REQ-006 SHALL have port btn_inc  input  1  debounced increment button, asynchronous, active-high.
REQ-007 SHALL have ports hr_tens[1:0], hr_ones[3:0], min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]  output  BCD time digits.
REQ-008 SHALL have port mode  output  2  current state encoding (RUN=0, SET_HOUR=1, SET_MIN=2).
REQ-009 SHALL have port day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.

Function
REQ-010 SHALL derive sec_strobe, a one-cycle pulse, from tick_1hz rising edge (tick_1hz registered once; strobe = tick & ~tick_q); tick_1hz itself is not resynchronized.
REQ-011 SHALL pass btn_mode and btn_inc through SYNC_STAGES flops, then rising-edge detect to one-cycle mode_ev / inc_ev; latency from pin to event SHALL be SYNC_STAGES+1 cycles.
REQ-012 SHALL implement FSM RUN -> SET_HOUR -> SET_MIN -> RUN, advancing one state per mode_ev.
REQ-013 In RUN, each sec_strobe SHALL increment seconds; seconds 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours; hours 23 -> 00 asserts day_wrap for the same cycle the digits update.
REQ-014 In RUN, inc_ev SHALL be ignored.
REQ-015 On transition RUN -> SET_HOUR, seconds SHALL clear to 00 on that cycle.
REQ-016 In SET_HOUR and SET_MIN, sec_strobe SHALL be ignored (time frozen, seconds held at 00).
REQ-017 In SET_HOUR, inc_ev SHALL increment hours modulo 24 with no carry into or out of other fields, and no day_wrap.
REQ-018 In SET_MIN, inc_ev SHALL increment minutes modulo 60 with no carry into hours.
REQ-019 On SET_MIN -> RUN, counting SHALL resume from HH:MM:00; the first increment occurs on the next sec_strobe.
REQ-020 When mode_ev and inc_ev occur in the same cycle, mode_ev SHALL take effect and inc_ev SHALL be discarded.
REQ-021 When mode_ev and sec_strobe coincide in RUN, the seconds clear from REQ-015 SHALL win; no carry propagates.
REQ-022 All digits SHALL always hold legal BCD (ones 0..9, sec/min tens 0..5, hour 00..23); digit outputs SHALL be registered, no combinational path from inputs.

Reset
REQ-023 reset_n low SHALL asynchronously force time 00:00:00, mode=RUN, day_wrap=0, all synchronizer and edge-detect flops to 0.
REQ-024 Reset asserted mid-operation (including mid-SET) SHALL discard pending events; after release, a button held high SHALL produce one event, and a tick_1hz already high SHALL produce no strobe until its next rising edge.

Structure
REQ-025 Shared package watch_pkg SHALL hold the mode state encoding and limit constants (SEC_MAX=59, MIN_MAX=59, HR_MAX=23).
REQ-026 Sub-module bcd_mod_counter SHALL implement a two-digit BCD counter with parameterized modulus, inc enable, clear, and carry-out; the block instantiates it three times (sec, min, hr).

Verification
REQ-027 Reset release, 60 tick_1hz rising edges -> time 00:01:00, mode=0, no day_wrap.
REQ-028 Preload via SET to 23:59, return to RUN, 59 ticks then 1 tick -> 23:59:59 then 00:00:00 with day_wrap high exactly one cycle.
REQ-029 mode press, 25 inc presses in SET_HOUR -> hr=01; mode, 61 inc presses -> min=01, hours unchanged, no day_wrap.
REQ-030 btn_mode and btn_inc rising together in RUN -> mode=1, hours unchanged; during SET states, 5 ticks -> seconds remain 00.
REQ-031 At 12:34:56 in RUN, assert reset_n low mid-cycle -> outputs 00:00:00, mode=0 immediately (before next clock edge).
REQ-032 btn_inc held high 1000 cycles in SET_MIN -> exactly one increment, observed SYNC_STAGES+1 cycles after assertion.
